// File: rtl/noise_channel_ctrl_pkg.sv
// Shared types and helpers for the noise channel sequencer and its LFSR.
package noise_channel_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam int          SYM_W     = 2;

  // Bit 1 of the symbol is steered by the high LFSR byte, bit 0 by the low byte.
  function automatic logic [SYM_W-1:0] flip_mask(input logic [15:0] lfsr,
                                                 input logic [7:0]  lvl);
    return {(lfsr[15:8] < lvl), (lfsr[7:0] < lvl)};
  endfunction

  function automatic logic [1:0] popcount2(input logic [1:0] m);
    return {m[1] & m[0], m[1] ^ m[0]};
  endfunction

endpackage

// File: rtl/noise_channel_if.sv
// Symbol stream bundle: encoder -> channel (in_*) and channel -> decoder (out_*).
interface noise_channel_if;
  import noise_channel_ctrl_pkg::*;

  // A beat transfers on a rising edge where valid && ready; a held valid keeps
  // its payload stable until it is taken, and ready may depend on valid.
  logic             in_valid;
  logic [SYM_W-1:0] in_sym;
  logic             in_ready;
  logic             out_valid;
  logic [SYM_W-1:0] out_sym;
  logic             out_ready;

  modport master (
    output in_valid, in_sym, out_ready,
    input  in_ready, out_valid, out_sym
  );

  modport slave (
    input  in_valid, in_sym, out_ready,
    output in_ready, out_valid, out_sym
  );

endinterface

// File: rtl/noise_lfsr16.sv
// 16-bit right-shifting Galois LFSR with synchronous load and step enable.
module noise_lfsr16
  import noise_channel_ctrl_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] POLY = LFSR_POLY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  input  logic        adv_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Load wins over advance so a restart always begins from the seed.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = seed_i;
    end else if (adv_i) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/noise_channel_ctrl.sv
// Frame sequencer: corrupts each accepted symbol with LFSR-driven bit flips and counts them.
module noise_channel_ctrl
  import noise_channel_ctrl_pkg::*;
#(
  parameter int          FRAME_LEN = 16,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           err_level,
  noise_channel_if.slave       bus,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           err_count,
  output state_e               dbg_state
);

  localparam logic [7:0] FRAME_N = 8'(FRAME_LEN);

  state_e           state_q;
  logic [7:0]       in_cnt_q;
  logic [7:0]       lvl_q;
  logic [7:0]       err_count_q;
  logic [7:0]       err_count_d;
  logic             out_valid_q;
  logic [SYM_W-1:0] out_sym_q;
  logic [15:0]      lfsr;
  logic             in_ready;
  logic             accept;
  logic             out_fire;
  logic             start_ok;
  logic [SYM_W-1:0] mask;
  logic [8:0]       err_sum;

  assign out_fire = out_valid_q && bus.out_ready;
  assign in_ready = (state_q == RUN) && (in_cnt_q < FRAME_N) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign start_ok = (state_q == IDLE) && start;

  assign mask        = flip_mask(lfsr, lvl_q);
  assign err_sum     = {1'b0, err_count_q} + 9'(popcount2(mask));
  assign err_count_d = err_sum[8] ? 8'hFF : err_sum[7:0];

  // Stepping only on accept keeps the noise pattern a function of symbol index alone.
  noise_lfsr16 #(
    .SEED (SEED),
    .POLY (LFSR_POLY)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (start_ok),
    .seed_i (SEED),
    .adv_i  (accept),
    .lfsr_o (lfsr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_cnt_q    <= 8'd0;
      lvl_q       <= 8'd0;
      err_count_q <= 8'd0;
      out_valid_q <= 1'b0;
      out_sym_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= RUN;
            lvl_q       <= err_level;
            in_cnt_q    <= 8'd0;
            err_count_q <= 8'd0;
          end
        end
        RUN: begin
          if (accept) begin
            out_sym_q   <= bus.in_sym ^ mask;
            out_valid_q <= 1'b1;
            in_cnt_q    <= in_cnt_q + 8'd1;
            err_count_q <= err_count_d;
          end else if (out_fire) begin
            out_valid_q <= 1'b0;
          end
          // Accept is blocked once the count is reached, so this fire is the last symbol.
          if (out_fire && (in_cnt_q == FRAME_N)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sym   = out_sym_q;
  assign busy          = (state_q == RUN);
  assign done          = (state_q == DONE);
  assign err_count     = err_count_q;
  assign dbg_state     = state_q;

endmodule
